// File: rtl/dna_search_sequencer.sv
// dna_search_sequencer: buffers search jobs in a 4-deep FIFO and issues them one at a time to the DNA pattern-search engine.
module dna_search_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic        clock,
  input  logic        reset_N,
  input  logic        job_valid,
  input  logic [15:0] job_dna_start,
  input  logic [15:0] job_dna_length,
  input  logic [11:0] job_pattern_start,
  output logic        job_ready,
  output logic        ready,
  output logic [15:0] dna_start,
  output logic [15:0] dna_length,
  output logic [11:0] pattern_start,
  input  logic        done,
  input  logic        found_it,
  input  logic        error,
  output logic        res_valid,
  output logic [7:0]  res_id,
  output logic        res_found,
  output logic        res_error,
  output logic        res_timeout,
  output logic [7:0]  hit_count,
  output logic [7:0]  err_count,
  output logic        busy,
  output logic        halted
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] ds;
    logic [15:0] dl;
    logic [11:0] ps;
  } job_t;
  job_t fifo_q [4];
  job_t fifo_d [4];
  job_t cur_q, cur_d;
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d, state_q, state_d;
  logic [7:0] id_q, id_d, res_id_q, res_id_d, hit_q, hit_d, err_q, err_d;
  logic [15:0] tmo_q, tmo_d;
  logic ready_q, ready_d, res_valid_q, res_valid_d, res_found_q, res_found_d;
  logic res_error_q, res_error_d, res_timeout_q, res_timeout_d;
  logic halted_q, halted_d, busy_q, busy_d, job_ready_q, job_ready_d;
  logic push, pop, fin, tmo_hit;
  assign push    = job_valid && job_ready_q;
  assign pop     = state_q == S_IDLE && cnt_q != 3'd0 && !halted_q;
  // done has priority over an expiring timeout in the same WAIT cycle
  assign fin     = state_q == S_WAIT && (done || tmo_q == TMO);
  assign tmo_hit = fin && !done;
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = {id_q, job_dna_start, job_dna_length, job_pattern_start};
    wr_d          = wr_q + 2'(push);
    rd_d          = rd_q + 2'(pop);
    cnt_d         = cnt_q + 3'(push) - 3'(pop);
    id_d          = id_q + 8'(push);
    cur_d         = pop ? fifo_q[rd_q] : cur_q;
    ready_d       = pop;
    tmo_d         = state_q == S_ARM ? 16'd0 : state_q == S_WAIT ? tmo_q + 16'd1 : tmo_q;
    res_valid_d   = fin;
    res_id_d      = fin ? cur_q.id : res_id_q;
    res_found_d   = fin ? done && found_it : res_found_q;
    res_error_d   = fin ? done && error : res_error_q;
    res_timeout_d = fin ? tmo_hit : res_timeout_q;
    hit_d         = hit_q + 8'(fin && done && found_it && hit_q != 8'hff);
    err_d         = err_q + 8'(fin && (tmo_hit || (done && error)) && err_q != 8'hff);
    halted_d      = halted_q || tmo_hit;
    case (state_q)
      S_IDLE:   state_d = pop ? S_ISSUE : S_IDLE;
      S_ISSUE:  state_d = S_ARM;
      S_ARM:    state_d = S_WAIT;
      S_WAIT:   state_d = fin ? S_REPORT : S_WAIT;
      S_REPORT: state_d = res_timeout_q ? S_HALT : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    busy_d        = state_d != S_IDLE || cnt_d != 3'd0;
    job_ready_d   = cnt_d < 3'd4;
  end
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      fifo_q        <= '{default: '0};
      cur_q         <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      id_q          <= '0;
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      ready_q       <= 1'b0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_found_q   <= 1'b0;
      res_error_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      hit_q         <= '0;
      err_q         <= '0;
      halted_q      <= 1'b0;
      busy_q        <= 1'b0;
      job_ready_q   <= 1'b1;
    end else begin
      fifo_q        <= fifo_d;
      cur_q         <= cur_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      ready_q       <= ready_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_found_q   <= res_found_d;
      res_error_q   <= res_error_d;
      res_timeout_q <= res_timeout_d;
      hit_q         <= hit_d;
      err_q         <= err_d;
      halted_q      <= halted_d;
      busy_q        <= busy_d;
      job_ready_q   <= job_ready_d;
    end
  end
  assign job_ready     = job_ready_q;
  assign ready         = ready_q;
  assign dna_start     = cur_q.ds;
  assign dna_length    = cur_q.dl;
  assign pattern_start = cur_q.ps;
  assign res_valid     = res_valid_q;
  assign res_id        = res_id_q;
  assign res_found     = res_found_q;
  assign res_error     = res_error_q;
  assign res_timeout   = res_timeout_q;
  assign hit_count     = hit_q;
  assign err_count     = err_q;
  assign busy          = busy_q;
  assign halted        = halted_q;
endmodule
